// File: rtl/fpmul_op_sender.sv
// ---------------------------------------------------------------------------
// fpmul_op_sender
//   Initiator side of the FP-multiplier valid/ready stream. Operand pairs are
//   buffered in a small FIFO and issued one at a time to the multiplier
//   wrapper. The product is collected on the wrapper's result port, with at
//   most one transaction in flight. Lost pushes, spurious results and missing
//   results are reported through sticky error flags.
//
//   Optional feature macro: FP_SEND_STATS_EN
//     When defined, adds the issued_cnt, done_cnt and last_latency outputs
//     (CNT_W bits each, saturating). When undefined, those ports and the
//     counters behind them do not exist.
// ---------------------------------------------------------------------------
module fpmul_op_sender #(
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    // operand writer side
    input  logic              op_wr_en,
    input  logic [DATA_W-1:0] op_wr_a,
    input  logic [DATA_W-1:0] op_wr_b,
    output logic              op_full,
    // wrapper input port
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              valid,
    input  logic              ready,
    // wrapper output port
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    // captured result and status
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    input  logic              clear_err,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              err_spurious
`ifdef FP_SEND_STATS_EN
    ,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  last_latency
`endif
);

    // -----------------------------------------------------------------------
    // Derived widths
    // -----------------------------------------------------------------------
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = PTR_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [FCNT_W-1:0]  FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);

    // Elaboration-time parameter sanity checks; none of these generate logic.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fpmul_op_sender: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYCLES < 8) begin : g_bad_timeout
        $error("fpmul_op_sender: TIMEOUT_CYCLES must be >= 8");
    end
    if ((DATA_W < 1) || (CNT_W < 1)) begin : g_bad_width
        $error("fpmul_op_sender: DATA_W and CNT_W must be >= 1");
    end

    // -----------------------------------------------------------------------
    // Types and state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // Response timer
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Next values of the registered outputs
    logic [DATA_W-1:0] a_d, b_d, result_d;
    logic              valid_d, res_ready_d, result_valid_d;

    // Events produced by the FSM
    logic handshake;      // operand pair accepted by the wrapper
    logic capture;        // product accepted from the wrapper
    logic timeout_evt;    // gave up waiting for a product

    // Error set events
    logic overflow_set;
    logic spurious_set;

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    assign op_full    = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    // A push while full is dropped even if a pop frees a slot in the same
    // cycle, because op_full is the registered count.
    assign push       = op_wr_en && !op_full;

    // FIFO data write port
    // NOTE: the storage array has no reset; only the pointers and count are
    // reset, which is enough to make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= op_wr_a;
            mem_b[wr_ptr] <= op_wr_b;
        end
    end

    // FIFO pointers and occupancy count
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM
    // -----------------------------------------------------------------------

    // State register and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid        <= 1'b0;
            res_ready    <= 1'b0;
            A            <= '0;
            B            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            valid        <= valid_d;
            res_ready    <= res_ready_d;
            A            <= a_d;
            B            <= b_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            timer_q      <= timer_d;
        end
    end

    // Next-state, output and event decode
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        valid_d        = valid;
        res_ready_d    = res_ready;
        a_d            = A;
        b_d            = B;
        result_d       = result;
        result_valid_d = 1'b0;
        timer_d        = timer_q;
        pop            = 1'b0;
        handshake      = 1'b0;
        capture        = 1'b0;
        timeout_evt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    a_d     = mem_a[rd_ptr];
                    b_d     = mem_b[rd_ptr];
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            // The wrapper may hold ready low indefinitely; no timeout here.
            S_ISSUE: begin
                if (valid && ready) begin
                    handshake   = 1'b1;
                    valid_d     = 1'b0;
                    res_ready_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_WAIT_RES;
                end
            end

            // A result arriving on the last timer cycle still wins.
            S_WAIT_RES: begin
                if (res_valid && res_ready) begin
                    capture        = 1'b1;
                    result_d       = res_data;
                    result_valid_d = 1'b1;
                    res_ready_d    = 1'b0;
                    state_d        = S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_evt = 1'b1;
                    res_ready_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                valid_d     = 1'b0;
                res_ready_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // Sticky error flags; a set event beats a simultaneous clear.
    // -----------------------------------------------------------------------
    assign overflow_set = op_wr_en && op_full;
    assign spurious_set = res_valid && (state_q != S_WAIT_RES);

    // Error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (overflow_set) begin
                err_overflow <= 1'b1;
            end else if (clear_err) begin
                err_overflow <= 1'b0;
            end

            if (timeout_evt) begin
                err_timeout <= 1'b1;
            end else if (clear_err) begin
                err_timeout <= 1'b0;
            end

            if (spurious_set) begin
                err_spurious <= 1'b1;
            end else if (clear_err) begin
                err_spurious <= 1'b0;
            end
        end
    end

`ifdef FP_SEND_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics (saturating)
    // -----------------------------------------------------------------------
    // The timer reads k-1 on the k-th edge after the handshake, so the
    // handshake-to-capture distance is timer + 1. The sum is formed wide
    // enough to never wrap before it is saturated into CNT_W bits.
    localparam int LAT_W = (CNT_W > TIMER_W) ? (CNT_W + 1) : (TIMER_W + 1);
    localparam logic [LAT_W-1:0] LAT_SAT = LAT_W'({CNT_W{1'b1}});

    logic [LAT_W-1:0] lat_ext;
    assign lat_ext = LAT_W'(timer_q) + LAT_W'(1);

    // Issue/done counters and latency of the last captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt   <= '0;
            done_cnt     <= '0;
            last_latency <= '0;
        end else begin
            if (handshake && (issued_cnt != '1)) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
            if (capture) begin
                if (done_cnt != '1) begin
                    done_cnt <= done_cnt + CNT_W'(1);
                end
                last_latency <= (lat_ext > LAT_SAT) ? '1 : CNT_W'(lat_ext);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpmul_op_sender.sv
// ---------------------------------------------------------------------------
// tb_fpmul_op_sender
//   Directed bench for fpmul_op_sender. A behavioural multiplier wrapper
//   accepts operand pairs, checks them against the pairs queued by the
//   stimulus, and returns the hand-computed product 6 cycles after the
//   operand handshake (or never, for pairs marked to be dropped). A scoreboard
//   queue holds the expected products; a monitor pops and compares on every
//   result_valid pulse. Build with +define+FP_SEND_STATS_EN to also cover the
//   statistics outputs.
// ---------------------------------------------------------------------------
module tb_fpmul_op_sender;

    localparam int DW = 32;
    localparam int WRAP_LAT = 6;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] p;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_wr_en;
    logic [DW-1:0] op_wr_a, op_wr_b;
    logic          op_full;
    logic [DW-1:0] A, B;
    logic          valid;
    logic          ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          clear_err;
    logic          err_overflow, err_timeout, err_spurious;
`ifdef FP_SEND_STATS_EN
    logic [15:0]   issued_cnt, done_cnt, last_latency;
`endif

    // Wrapper model drive and spurious-result injection
    logic          model_valid;
    logic [DW-1:0] model_data;
    logic          spur_valid;
    logic [DW-1:0] spur_data;
    assign res_valid = model_valid | spur_valid;
    assign res_data  = spur_valid ? spur_data : model_data;

    // Scoreboard state
    vec_t          op_q[$];     // pairs expected at the wrapper, in order
    logic [DW-1:0] exp_q[$];    // products expected on result
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_pulses = 0;
    int            drop_req = 0;   // owned by stimulus
    int            drops_done = 0; // owned by the wrapper model

    fpmul_op_sender #(
        .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .op_wr_en(op_wr_en), .op_wr_a(op_wr_a), .op_wr_b(op_wr_b), .op_full(op_full),
        .A(A), .B(B), .valid(valid), .ready(ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .result_valid(result_valid), .busy(busy),
        .clear_err(clear_err),
        .err_overflow(err_overflow), .err_timeout(err_timeout), .err_spurious(err_spurious)
`ifdef FP_SEND_STATS_EN
        ,
        .issued_cnt(issued_cnt), .done_cnt(done_cnt), .last_latency(last_latency)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n clock edges, ending 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] p,
                        input bit accepted, input bit returns);
        vec_t v;
        v.a = a; v.b = b; v.p = p;
        if (accepted) begin
            op_q.push_back(v);
            if (returns) exp_q.push_back(p);
        end
        op_wr_a  = a;
        op_wr_b  = b;
        op_wr_en = 1'b1;
        step(1);
        op_wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || op_q.size() != 0 || busy) && n < max_cycles) begin
            step(1);
            n++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && op_q.size() == 0 && !busy)}, 32'd1);
    endtask

    task automatic wait_res_ready(input int max_cycles);
        int n = 0;
        while (res_ready !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check("res_ready_seen", {31'd0, res_ready}, 32'd1);
    endtask

    // Wrapper model: decides at the falling edge what happens on the next
    // rising edge. Handshake at edge h -> res_valid high for edge h+6.
    initial begin
        int   lat_cnt;
        bit   pending;
        logic [DW-1:0] pend_p;
        vec_t v;
        model_valid = 1'b0;
        model_data  = '0;
        lat_cnt     = 0;
        pending     = 1'b0;
        pend_p      = '0;
        forever begin
            @(negedge clk);
            if (model_valid) model_valid = 1'b0;
            if (pending) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    model_valid = 1'b1;
                    model_data  = pend_p;
                    pending     = 1'b0;
                end
            end
            if (valid === 1'b1 && ready === 1'b1 && rst === 1'b0) begin
                if (op_q.size() == 0) begin
                    check("unexpected_issue", {31'd0, valid}, 32'd0);
                end else begin
                    v = op_q.pop_front();
                    check("issue_a", A, v.a);
                    check("issue_b", B, v.b);
                    if (drops_done < drop_req) begin
                        drops_done++;
                    end else begin
                        pending = 1'b1;
                        lat_cnt = WRAP_LAT;
                        pend_p  = v.p;
                    end
                end
            end
        end
    end

    // Result monitor / scoreboard compare
    initial begin
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                n_pulses++;
                if (exp_q.size() == 0) check("unexpected_result_pulse", {31'd0, result_valid}, 32'd0);
                else check("result", result, exp_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst = 1'b1; op_wr_en = 1'b0; op_wr_a = '0; op_wr_b = '0;
        ready = 1'b0; clear_err = 1'b0; spur_valid = 1'b0; spur_data = '0;
        step(3);

        // ---- reset state ----
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_res_ready", {31'd0, res_ready}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_full", {31'd0, op_full}, 32'd0);
        check("rst_errs", {29'd0, err_overflow, err_timeout, err_spurious}, 32'd0);
        check("rst_a", A, 32'd0);
        check("rst_b", B, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        step(1);

        // ---- single pair, 3.0 * 2.0 = 6.0 ----
        ready = 1'b1;
        push(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b1, 1'b1);
        check("valid_not_yet", {31'd0, valid}, 32'd0);
        step(1);
        check("valid_issued", {31'd0, valid}, 32'd1);
        check("a_driven", A, 32'h4040_0000);
        check("b_driven", B, 32'h4000_0000);
        wait_drain(100);
        check("single_pulse_count", n_pulses, 32'd1);
        check("single_result", result, 32'h40C0_0000);
        check("pulse_dropped", {31'd0, result_valid}, 32'd0);

        // ---- fill FIFO while wrapper stalls, then overflow ----
        ready = 1'b0;
        push(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, 1'b1); // 1.5*2=3
        push(32'hC000_0000, 32'h4080_0000, 32'hC100_0000, 1'b1, 1'b1); // -2*4=-8
        push(32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000, 1'b1, 1'b1); // .5*.5=.25
        push(32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, 1'b1, 1'b1); // 10*10=100
        push(32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b1, 1'b1); // 1*-1=-1
        check("full_after_4", {31'd0, op_full}, 32'd1);
        check("no_overflow_yet", {31'd0, err_overflow}, 32'd0);
        push(32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000, 1'b0, 1'b0); // dropped
        check("overflow_set", {31'd0, err_overflow}, 32'd1);
        check("stall_valid", {31'd0, valid}, 32'd1);
        step(5);
        check("stall_valid_held", {31'd0, valid}, 32'd1);
        check("stall_a_stable", A, 32'h3FC0_0000);
        check("stall_b_stable", B, 32'h4000_0000);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("overflow_cleared", {31'd0, err_overflow}, 32'd0);
        check("still_full", {31'd0, op_full}, 32'd1);
        ready = 1'b1;
        wait_drain(200);
        check("drained_not_full", {31'd0, op_full}, 32'd0);
        check("burst_pulse_count", n_pulses, 32'd6);

        // ---- timeout: wrapper never answers the first pair ----
        drop_req = 1;
        push(32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000, 1'b1, 1'b0); // lost
        push(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 1'b1, 1'b1); // 3*3=9
        wait_res_ready(10);
        step(63);
        check("timeout_not_yet", {31'd0, err_timeout}, 32'd0);
        check("still_waiting", {31'd0, res_ready}, 32'd1);
        step(1);
        check("timeout_set", {31'd0, err_timeout}, 32'd1);
        check("timeout_res_ready_low", {31'd0, res_ready}, 32'd0);
        check("timeout_result_kept", result, 32'hBF80_0000);
        wait_drain(100);
        check("after_timeout_result", result, 32'h4110_0000);
        check("timeout_sticky", {31'd0, err_timeout}, 32'd1);

        // ---- spurious result while idle ----
        spur_data  = 32'h1234_5678;
        spur_valid = 1'b1;
        step(1);
        spur_valid = 1'b0;
        check("spurious_set", {31'd0, err_spurious}, 32'd1);
        check("spurious_result_kept", result, 32'h4110_0000);
        check("spurious_no_pulse", {31'd0, result_valid}, 32'd0);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("clear_errs", {29'd0, err_overflow, err_timeout, err_spurious}, 32'd0);
        spur_valid = 1'b1;
        clear_err  = 1'b1;
        step(1);
        spur_valid = 1'b0;
        clear_err  = 1'b0;
        check("set_beats_clear", {31'd0, err_spurious}, 32'd1);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("spurious_cleared", {31'd0, err_spurious}, 32'd0);

        // ---- reset during WAIT_RES with two pairs queued ----
        drop_req = 2;
        push(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0);
        push(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0);
        push(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b0);
        wait_res_ready(10);
        step(2);
        check("mid_wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step(1);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_res_ready", {31'd0, res_ready}, 32'd0);
        check("mid_rst_op_full", {31'd0, op_full}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        rst = 1'b0;
        op_q.delete();
        step(6);
        check("post_rst_fifo_empty", {30'd0, valid, busy}, 32'd0);
        check("post_rst_pulse_count", n_pulses, 32'd7);

        // ---- three pairs back to back ----
        push(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b1, 1'b1); // 2*2=4
        push(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1, 1'b1); // 1.5^2=2.25
        push(32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 1'b1, 1'b1); // -3*.5=-1.5
        wait_drain(100);
        check("final_result", result, 32'hBFC0_0000);
`ifdef FP_SEND_STATS_EN
        check("stats_issued", {16'd0, issued_cnt}, 32'd3);
        check("stats_done", {16'd0, done_cnt}, 32'd3);
        check("stats_latency", {16'd0, last_latency}, 32'd6);
`endif
        step(3);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("total_pulses", n_pulses, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
